fft_input_loader: RTL and testbench

FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

---
 rtl/fft_input_loader.sv | 115 +++++++++++
 tb/tb_fft_input_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_loader.sv
// rtl/fft_input_loader.sv - collects N complex samples into a frame, then holds it while the FFT runs.
// Optional in_last framing checks are enabled by defining FFT_LOADER_LAST_CHECK_EN.
module fft_input_loader #(
  parameter int DATA_W = 32,
  parameter int N      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_real,
  input  logic [DATA_W-1:0]   in_imag,
  input  logic                in_last,
  output logic [N*DATA_W-1:0] X_real_flat,
  output logic [N*DATA_W-1:0] X_imag_flat,
  output logic                start,
  input  logic                fft_valid,
  output logic                frame_done,
  output logic                busy,
  output logic                frame_err
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {FILL, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] wr_idx, wr_idx_nxt;
  logic [DATA_W-1:0] re_mem [N];
  logic [DATA_W-1:0] im_mem [N];
  logic             accept, frame_end, discard, slot_we;

  assign in_ready   = (state == FILL);
  assign start      = (state == RUN);
  assign frame_done = (state == DONE);
  assign busy       = (state != FILL);

  assign accept    = in_valid && in_ready;
  assign frame_end = accept && (wr_idx == LAST_IDX);

`ifdef FFT_LOADER_LAST_CHECK_EN
  logic long_frame;
  // A premature in_last drops the partial frame; a missing one only flags it.
  assign discard    = accept && in_last && (wr_idx != LAST_IDX);
  assign long_frame = frame_end && !in_last;
  assign slot_we    = accept && !discard;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      frame_err <= 1'b0;
    else if (discard || long_frame)
      frame_err <= 1'b1;
  end
`else
  logic unused_last;
  assign unused_last = in_last;
  assign discard     = 1'b0;
  assign slot_we     = accept;
  assign frame_err   = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    wr_idx_nxt = wr_idx;
    case (state)
      FILL: begin
        if (frame_end) begin
          state_nxt  = RUN;
          wr_idx_nxt = '0;
        end else if (discard) begin
          wr_idx_nxt = '0;
        end else if (accept) begin
          wr_idx_nxt = wr_idx + 1'b1;
        end
      end
      RUN:     if (fft_valid) state_nxt = DONE;
      DONE:    state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FILL;
      wr_idx <= '0;
    end else begin
      state  <= state_nxt;
      wr_idx <= wr_idx_nxt;
    end
  end

  // Slots are only written in FILL, so the frame is frozen through RUN and DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        re_mem[i] <= '0;
        im_mem[i] <= '0;
      end
    end else if (slot_we) begin
      re_mem[wr_idx] <= in_real;
      im_mem[wr_idx] <= in_imag;
    end
  end

  always_comb begin
    X_real_flat = '0;
    X_imag_flat = '0;
    for (int k = 0; k < N; k++) begin
      X_real_flat[k*DATA_W +: DATA_W] = re_mem[k];
      X_imag_flat[k*DATA_W +: DATA_W] = im_mem[k];
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// tb/tb_fft_input_loader.sv - directed bench for fft_input_loader (N=32, DATA_W=32).
// Framing-error cases follow FFT_LOADER_LAST_CHECK_EN when it is defined.
module tb_fft_input_loader;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_real;
  logic [31:0]   in_imag;
  logic          in_last;
  logic [1023:0] X_real_flat;
  logic [1023:0] X_imag_flat;
  logic          start;
  logic          fft_valid;
  logic          frame_done;
  logic          busy;
  logic          frame_err;

  int checks   = 0;
  int failures = 0;

  fft_input_loader #(.DATA_W(32), .N(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_real    (in_real),
    .in_imag    (in_imag),
    .in_last    (in_last),
    .X_real_flat(X_real_flat),
    .X_imag_flat(X_imag_flat),
    .start      (start),
    .fft_valid  (fft_valid),
    .frame_done (frame_done),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] re_slot(input int k);
    return X_real_flat[k*32 +: 32];
  endfunction

  function automatic logic [31:0] im_slot(input int k);
    return X_imag_flat[k*32 +: 32];
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the sample was accepted.
  task automatic send(input logic [31:0] re, input logic [31:0] im, input logic last);
    int   n   = 0;
    logic acc = 1'b0;
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    in_last  = last;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic end_run();
    fft_valid = 1'b1;
    @(posedge clk);
    #1;
    fft_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1023:0] snap_re, snap_im;
    int            start_low, k, cyc, early;

    reset = 1'b0; in_valid = 1'b0; in_real = '0; in_imag = '0; in_last = 1'b0; fft_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start", start, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_x_real_zero", X_real_flat == '0, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // fft_valid in FILL must be ignored
    fft_valid = 1'b1;
    @(posedge clk);
    #1;
    fft_valid = 1'b0;
    check("fill_ign_fft_busy", busy, 0);
    check("fill_ign_fft_done", frame_done, 0);

    // Frame 1: real = k, imag = -k on consecutive cycles
    for (int i = 0; i < 31; i++) send(32'(i), 32'(-i), 1'b0);
    check("f1_start_before_last", start, 0);
    send(32'd31, 32'(-31), 1'b1);
    check("f1_start", start, 1);
    check("f1_busy", busy, 1);
    check("f1_in_ready", in_ready, 0);
    check("f1_slot5_re", re_slot(5), 32'd5);
    check("f1_slot5_im", im_slot(5), 32'hFFFF_FFFB);
    check("f1_slot31_re", re_slot(31), 32'd31);

    // Hold in_valid with changing data through RUN
    snap_re = X_real_flat;
    snap_im = X_imag_flat;
    start_low = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 36; i++) begin
      in_real = $urandom;
      in_imag = $urandom;
      @(posedge clk);
      #1;
      if (start !== 1'b1) start_low++;
    end
    check("run_start_held", start_low, 0);
    check("run_hold_re", X_real_flat == snap_re, 1);
    check("run_hold_im", X_imag_flat == snap_im, 1);
    in_real = 32'h1234;
    in_imag = 32'h5678;
    fft_valid = 1'b1;
    @(posedge clk);
    #1;
    fft_valid = 1'b0;
    check("done_pulse", frame_done, 1);
    check("done_start_low", start, 0);
    check("done_in_ready", in_ready, 0);
    check("done_busy", busy, 1);
    check("done_hold_re", X_real_flat == snap_re, 1);
    @(posedge clk);
    #1;
    check("fill_done_low", frame_done, 0);
    check("fill_in_ready", in_ready, 1);
    check("fill_busy", busy, 0);
    check("fill_no_early_accept", re_slot(0), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("fill_accept_slot0", re_slot(0), 32'h1234);
    check("fill_accept_slot1", re_slot(1), 32'd1);

    // Frame 2: in_valid toggles randomly
    do_reset();
    k = 0; cyc = 0; early = 0;
    while (k < 32 && cyc < 1000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_real  = 32'(100 + k);
      in_imag  = 32'(200 + k);
      in_last  = (k == 31);
      @(negedge clk);
      if (!in_ready) early++;
      if (in_valid && in_ready) k++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("rand_count", k, 32);
    check("rand_ready_early", early, 0);
    check("rand_start", start, 1);
    for (int i = 0; i < 32; i++) begin
      check("rand_slot_re", re_slot(i), 32'(100 + i));
      check("rand_slot_im", im_slot(i), 32'(200 + i));
    end
    end_run();
    check("rand_back_fill", in_ready, 1);

    // Reset after 10 samples
    for (int i = 0; i < 10; i++) send(32'(i + 1), 32'(i + 1), 1'b0);
    check("part_slot9", re_slot(9), 32'd10);
    reset = 1'b0;
    #1;
    check("mid_rst_re_zero", X_real_flat == '0, 1);
    check("mid_rst_im_zero", X_imag_flat == '0, 1);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_start", start, 0);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    send(32'hAA, 32'hBB, 1'b0);
    check("post_rst_slot0_re", re_slot(0), 32'hAA);
    check("post_rst_slot0_im", im_slot(0), 32'hBB);
    check("post_rst_slot1_re", re_slot(1), 32'd0);

    // Early in_last on sample 7
    do_reset();
    for (int i = 0; i < 7; i++) send(32'(50 + i), 32'd0, 1'b0);
    send(32'd57, 32'd0, 1'b1);
`ifdef FFT_LOADER_LAST_CHECK_EN
    check("err_set", frame_err, 1);
    check("err_no_start", start, 0);
    check("err_busy", busy, 0);
    for (int i = 0; i < 32; i++) send(32'(300 + i), 32'd0, i == 31);
    check("err_next_start", start, 1);
    check("err_sticky", frame_err, 1);
    check("err_next_slot0", re_slot(0), 32'd300);
    check("err_next_slot7", re_slot(7), 32'd307);
`else
    check("nolast_err", frame_err, 0);
    check("nolast_no_start", start, 0);
    for (int i = 8; i < 32; i++) send(32'(50 + i), 32'd0, i == 31);
    check("nolast_start", start, 1);
    check("nolast_err_after", frame_err, 0);
    check("nolast_slot7", re_slot(7), 32'd57);
    check("nolast_slot31", re_slot(31), 32'd81);
`endif
    end_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
